// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch front-panel controller: FSM state codes,
// digit-select codes and per-digit wrap limits.
package stopwatch_pkg;

    localparam logic [1:0] ST_STOP  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_ADJ   = 2'd3;

    localparam logic [2:0] SEL_NONE  = 3'd0;
    localparam logic [2:0] SEL_MIN_L = 3'd1;
    localparam logic [2:0] SEL_MIN_R = 3'd2;
    localparam logic [2:0] SEL_SEC_L = 3'd3;
    localparam logic [2:0] SEL_SEC_R = 3'd4;

    localparam logic [4:0] LIM_TENS = 5'd5;
    localparam logic [4:0] LIM_ONES = 5'd9;

    // Highest legal value of the selected digit; tens digits stop at 5.
    function automatic logic [4:0] digit_limit(input logic [2:0] sel);
        case (sel)
            SEL_MIN_L, SEL_SEC_L: digit_limit = LIM_TENS;
            SEL_MIN_R, SEL_SEC_R: digit_limit = LIM_ONES;
            default:              digit_limit = 5'd0;
        endcase
    endfunction

    function automatic logic [2:0] next_sel(input logic [2:0] sel);
        case (sel)
            SEL_MIN_L: next_sel = SEL_MIN_R;
            SEL_MIN_R: next_sel = SEL_SEC_L;
            SEL_SEC_L: next_sel = SEL_SEC_R;
            SEL_SEC_R: next_sel = SEL_MIN_L;
            default:   next_sel = SEL_MIN_L;
        endcase
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_debounce.sv
// btn_debounce: 2-flop synchronizer, stability-count debouncer and a one-cycle
// registered rising-edge pulse of the debounced level.
module btn_debounce #(
    parameter int DB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          level_dly_q;
    logic          press_q;
    logic [CW-1:0] cnt_q, cnt_d;

    // Count consecutive disagreeing cycles; flip on the DB_CYCLES-th one.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q == level_q) begin
            cnt_d   = '0;
            level_d = level_q;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            level_d = ~level_q;
        end else begin
            cnt_d   = cnt_q + CW'(1);
            level_d = level_q;
        end
    end

    // Synchronizer, debounce state and edge pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            cnt_q       <= '0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            press_q     <= 1'b0;
        end else begin
            sync1_q     <= raw;
            sync2_q     <= sync1_q;
            cnt_q       <= cnt_d;
            level_q     <= level_d;
            level_dly_q <= level_q;
            press_q     <= level_q & ~level_dly_q;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch front-panel controller: STOP/RUN/PAUSE/ADJ FSM driving the counter.
// Optional STOPWATCH_BLINK_EN adds blink_mask for the digit being adjusted.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DB_CYCLES = 16,
    parameter int BLINK_DIV = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_pause,
    input  logic       btn_reset,
    input  logic       btn_sel,
    input  logic       btn_inc,
    input  logic       sw_adj,
    output logic       cnt_rst,
    output logic       paused,
    output logic [2:0] adj_sel,
    output logic [4:0] adj_val,
`ifdef STOPWATCH_BLINK_EN
    output logic [3:0] blink_mask,
`endif
    output logic [1:0] state
);

    logic pause_p, reset_p, sel_p, inc_p, adj_lvl;
    logic pause_lvl_unused, reset_lvl_unused, sel_lvl_unused, inc_lvl_unused;
    logic adj_press_unused;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_pause (
        .clk(clk), .rst(rst), .raw(btn_pause), .level(pause_lvl_unused), .press(pause_p));
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_reset (
        .clk(clk), .rst(rst), .raw(btn_reset), .level(reset_lvl_unused), .press(reset_p));
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_sel (
        .clk(clk), .rst(rst), .raw(btn_sel), .level(sel_lvl_unused), .press(sel_p));
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_inc (
        .clk(clk), .rst(rst), .raw(btn_inc), .level(inc_lvl_unused), .press(inc_p));
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_adj (
        .clk(clk), .rst(rst), .raw(sw_adj), .level(adj_lvl), .press(adj_press_unused));

    logic [1:0] state_q, state_d;
    logic       cnt_rst_q, cnt_rst_d;
    logic       paused_q, paused_d;
    logic [2:0] adj_sel_q, adj_sel_d;
    logic [4:0] adj_val_q, adj_val_d;

    // Next-state logic; outside ADJ a clear beats the switch, which beats pause.
    always_comb begin
        state_d   = state_q;
        cnt_rst_d = 1'b0;
        adj_sel_d = adj_sel_q;
        adj_val_d = adj_val_q;
        case (state_q)
            ST_STOP, ST_PAUSE: begin
                if (reset_p) begin
                    state_d   = ST_STOP;
                    cnt_rst_d = 1'b1;
                end else if (adj_lvl) begin
                    state_d   = ST_ADJ;
                    adj_sel_d = SEL_MIN_L;
                    adj_val_d = 5'd0;
                end else if (pause_p) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = state_q;
                end
            end
            ST_RUN: begin
                if (reset_p) begin
                    state_d   = ST_STOP;
                    cnt_rst_d = 1'b1;
                end else if (pause_p) begin
                    state_d = ST_PAUSE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_ADJ: begin
                if (!adj_lvl) begin
                    state_d   = ST_PAUSE;
                    adj_sel_d = SEL_NONE;
                    adj_val_d = 5'd0;
                end else if (sel_p) begin
                    adj_sel_d = next_sel(adj_sel_q);
                    adj_val_d = 5'd0;
                end else if (inc_p) begin
                    if (adj_val_q >= digit_limit(adj_sel_q)) begin
                        adj_val_d = 5'd0;
                    end else begin
                        adj_val_d = adj_val_q + 5'd1;
                    end
                end else begin
                    adj_val_d = adj_val_q;
                end
            end
            default: begin
                state_d   = ST_STOP;
                adj_sel_d = SEL_NONE;
                adj_val_d = 5'd0;
            end
        endcase
        paused_d = (state_d != ST_RUN);
    end

    // Registered FSM state and counter-facing outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_STOP;
            cnt_rst_q <= 1'b1;
            paused_q  <= 1'b1;
            adj_sel_q <= SEL_NONE;
            adj_val_q <= 5'd0;
        end else begin
            state_q   <= state_d;
            cnt_rst_q <= cnt_rst_d;
            paused_q  <= paused_d;
            adj_sel_q <= adj_sel_d;
            adj_val_q <= adj_val_d;
        end
    end

    assign state   = state_q;
    assign cnt_rst = cnt_rst_q;
    assign paused  = paused_q;
    assign adj_sel = adj_sel_q;
    assign adj_val = adj_val_q;

`ifdef STOPWATCH_BLINK_EN
    localparam int BW = $clog2(BLINK_DIV + 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_on_q, blink_on_d;
    logic [3:0]    blink_mask_q, blink_mask_d;

    // Blink phase restarts lit on ADJ entry and on every digit change.
    always_comb begin
        blink_cnt_d  = '0;
        blink_on_d   = 1'b1;
        blink_mask_d = 4'b1111;
        if (state_d == ST_ADJ) begin
            if ((state_q != ST_ADJ) || (adj_sel_d != adj_sel_q)) begin
                blink_cnt_d = '0;
                blink_on_d  = 1'b1;
            end else if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                blink_on_d  = ~blink_on_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
                blink_on_d  = blink_on_q;
            end
            case (adj_sel_d)
                SEL_MIN_L: blink_mask_d = {blink_on_d, 3'b111};
                SEL_MIN_R: blink_mask_d = {1'b1, blink_on_d, 2'b11};
                SEL_SEC_L: blink_mask_d = {2'b11, blink_on_d, 1'b1};
                SEL_SEC_R: blink_mask_d = {3'b111, blink_on_d};
                default:   blink_mask_d = 4'b1111;
            endcase
        end else begin
            blink_cnt_d  = '0;
            blink_on_d   = 1'b1;
            blink_mask_d = 4'b1111;
        end
    end

    // Blink counter and registered mask.
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt_q  <= '0;
            blink_on_q   <= 1'b1;
            blink_mask_q <= 4'b1111;
        end else begin
            blink_cnt_q  <= blink_cnt_d;
            blink_on_q   <= blink_on_d;
            blink_mask_q <= blink_mask_d;
        end
    end

    assign blink_mask = blink_mask_q;
`else
    localparam int BLINK_DIV_unused = BLINK_DIV;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl with DB_CYCLES=4, BLINK_DIV=4:
// directed scenarios plus a randomized button/switch sequence against a panel model.
module tb_stopwatch_ctrl;

    localparam int DB     = 4;
    localparam int BD     = 4;
    localparam int SETTLE = DB + 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] btn = 4'b0000;   // 0 pause, 1 reset, 2 sel, 3 inc
    logic       sw  = 1'b0;
    logic       cnt_rst, paused;
    logic [2:0] adj_sel;
    logic [4:0] adj_val;
    logic [1:0] state;
`ifdef STOPWATCH_BLINK_EN
    logic [3:0] blink_mask;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Panel model: state code, selected digit, digit value, debounced switch.
    int m_state, m_sel, m_val;
    bit m_sw;

    stopwatch_ctrl #(.DB_CYCLES(DB), .BLINK_DIV(BD)) dut (
        .clk(clk), .rst(rst),
        .btn_pause(btn[0]), .btn_reset(btn[1]), .btn_sel(btn[2]), .btn_inc(btn[3]),
        .sw_adj(sw),
        .cnt_rst(cnt_rst), .paused(paused), .adj_sel(adj_sel), .adj_val(adj_val),
`ifdef STOPWATCH_BLINK_EN
        .blink_mask(blink_mask),
`endif
        .state(state)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, got no summary, required completion");
        $fatal(1);
    end

    function automatic void m_settle();
        if ((m_state == 0 || m_state == 2) && m_sw) begin
            m_state = 3; m_sel = 1; m_val = 0;
        end
    endfunction

    function automatic void m_event(input int kind);
        int lim;
        if (m_state == 3) begin
            if (kind == 2) begin
                m_sel = (m_sel % 4) + 1; m_val = 0;
            end else if (kind == 3) begin
                lim   = (m_sel == 1 || m_sel == 3) ? 5 : 9;
                m_val = (m_val + 1) % (lim + 1);
            end
        end else if (kind == 1) begin
            m_state = 0;
        end else if (kind == 0) begin
            m_state = (m_state == 1) ? 2 : 1;
        end
        m_settle();
    endfunction

    function automatic void m_switch(input bit v);
        m_sw = v;
        if (m_state == 3 && !v) begin
            m_state = 2; m_sel = 0; m_val = 0;
        end
        m_settle();
    endfunction

    task automatic press(input int b, input int hold);
        @(negedge clk); btn[b] = 1'b1;
        repeat (hold) @(negedge clk);
        btn[b] = 1'b0;
        repeat (SETTLE) @(negedge clk);
    endtask

    task automatic set_sw(input logic v);
        @(negedge clk); sw = v;
        repeat (SETTLE) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; btn = 4'b0000; sw = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (cnt_rst !== 1'b1) begin n_fail++; $display("FAIL reset_cnt_rst: got %b, required 1", cnt_rst); end
        n_checks++; if (paused !== 1'b1) begin n_fail++; $display("FAIL reset_paused: got %b, required 1", paused); end
        n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d, required 0", state); end
        n_checks++; if (adj_sel !== 3'd0) begin n_fail++; $display("FAIL reset_adj_sel: got %0d, required 0", adj_sel); end
        n_checks++; if (adj_val !== 5'd0) begin n_fail++; $display("FAIL reset_adj_val: got %0d, required 0", adj_val); end
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (cnt_rst !== 1'b0) begin n_fail++; $display("FAIL release_cnt_rst: got %b, required 0", cnt_rst); end
    endtask

    task automatic test_pause_toggle();
        int first = 0;
        @(negedge clk); btn[0] = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk); #1;
            if (paused === 1'b0 && first == 0) first = e;
            if (e == 10) btn[0] = 1'b0;
        end
        n_checks++; if (first != DB + 4) begin n_fail++; $display("FAIL pause_latency: got %0d cycles, required %0d", first, DB + 4); end
        n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL run_state: got %0d, required 1", state); end
        repeat (SETTLE) @(negedge clk);
        press(0, $urandom_range(DB, 8));
        n_checks++; if (paused !== 1'b1) begin n_fail++; $display("FAIL pause_paused: got %b, required 1", paused); end
        n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL pause_state: got %0d, required 2", state); end
    endtask

    task automatic test_glitch();
        int changes = 0;
        int glen;
        @(negedge clk); btn[0] = 1'b1;
        for (int e = 1; e <= 23; e++) begin
            @(negedge clk);
            if (e == 3) btn[0] = 1'b0;
            if (state !== 2'd2) changes++;
        end
        n_checks++; if (changes != 0) begin n_fail++; $display("FAIL glitch_pause: got %0d changed cycles, required 0", changes); end
        glen = $urandom_range(1, DB - 1);
        press(1, glen);
        n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL glitch_reset: got state %0d, required 2", state); end
    endtask

    task automatic test_clear();
        int cnt = 0;
        int first = 0;
        press(0, $urandom_range(DB, 8));
        n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL clear_pre_run: got %0d, required 1", state); end
        @(negedge clk); btn[1] = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk); #1;
            if (cnt_rst === 1'b1) begin cnt++; if (first == 0) first = e; end
            if (e == 8) btn[1] = 1'b0;
        end
        n_checks++; if (cnt != 1) begin n_fail++; $display("FAIL clear_width: got %0d cycles, required 1", cnt); end
        n_checks++; if (first != DB + 4) begin n_fail++; $display("FAIL clear_latency: got %0d, required %0d", first, DB + 4); end
        n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL clear_state: got %0d, required 0", state); end
        n_checks++; if (paused !== 1'b1) begin n_fail++; $display("FAIL clear_paused: got %b, required 1", paused); end
    endtask

    task automatic test_adjust();
        press(0, $urandom_range(DB, 8));
        press(0, $urandom_range(DB, 8));
        n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL adj_pre_pause: got %0d, required 2", state); end
        set_sw(1'b1);
        n_checks++; if (state !== 2'd3) begin n_fail++; $display("FAIL adj_state: got %0d, required 3", state); end
        n_checks++; if (adj_sel !== 3'd1 || adj_val !== 5'd0) begin n_fail++; $display("FAIL adj_entry: got sel %0d val %0d, required sel 1 val 0", adj_sel, adj_val); end
        repeat (7) press(3, $urandom_range(DB, 8));
        n_checks++; if (adj_val !== 5'd1) begin n_fail++; $display("FAIL adj_wrap_tens: got %0d, required 1", adj_val); end
        press(2, $urandom_range(DB, 8));
        n_checks++; if (adj_sel !== 3'd2 || adj_val !== 5'd0) begin n_fail++; $display("FAIL adj_sel2: got sel %0d val %0d, required sel 2 val 0", adj_sel, adj_val); end
        repeat (9) press(3, $urandom_range(DB, 8));
        n_checks++; if (adj_val !== 5'd9) begin n_fail++; $display("FAIL adj_max_ones: got %0d, required 9", adj_val); end
        press(3, $urandom_range(DB, 8));
        n_checks++; if (adj_val !== 5'd0) begin n_fail++; $display("FAIL adj_wrap_ones: got %0d, required 0", adj_val); end
        repeat (3) press(2, $urandom_range(DB, 8));
        n_checks++; if (adj_sel !== 3'd1) begin n_fail++; $display("FAIL adj_sel_wrap: got %0d, required 1", adj_sel); end
        set_sw(1'b0);
        n_checks++; if (state !== 2'd2 || adj_sel !== 3'd0 || adj_val !== 5'd0) begin n_fail++; $display("FAIL adj_exit: got state %0d sel %0d val %0d, required 2 0 0", state, adj_sel, adj_val); end
    endtask

    task automatic test_simultaneous();
        int cnt = 0;
        set_sw(1'b1);
        press(3, $urandom_range(DB, 8));
        n_checks++; if (adj_val !== 5'd1) begin n_fail++; $display("FAIL simul_pre_inc: got %0d, required 1", adj_val); end
        @(negedge clk); btn[2] = 1'b1; btn[3] = 1'b1;
        repeat (6) @(negedge clk);
        btn[2] = 1'b0; btn[3] = 1'b0;
        repeat (SETTLE) @(negedge clk);
        n_checks++; if (adj_sel !== 3'd2 || adj_val !== 5'd0) begin n_fail++; $display("FAIL simul_sel_inc: got sel %0d val %0d, required sel 2 val 0", adj_sel, adj_val); end
        @(negedge clk); btn[1] = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk); #1;
            if (cnt_rst === 1'b1) cnt++;
            if (e == 8) btn[1] = 1'b0;
        end
        n_checks++; if (cnt != 0) begin n_fail++; $display("FAIL adj_reset_ignored: got %0d cnt_rst cycles, required 0", cnt); end
        n_checks++; if (state !== 2'd3 || adj_sel !== 3'd2) begin n_fail++; $display("FAIL adj_reset_state: got state %0d sel %0d, required 3 2", state, adj_sel); end
        set_sw(1'b0);
        press(0, $urandom_range(DB, 8));
        set_sw(1'b1);
        n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL run_ignores_sw: got %0d, required 1", state); end
        set_sw(1'b0);
    endtask

    task automatic test_mid_reset();
        int bad = 0;
        press(0, $urandom_range(DB, 8));
        set_sw(1'b1);
        press(2, $urandom_range(DB, 8));
        n_checks++; if (adj_sel !== 3'd2) begin n_fail++; $display("FAIL midrst_pre_sel: got %0d, required 2", adj_sel); end
        @(negedge clk); rst = 1'b1; sw = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (state !== 2'd0 || adj_sel !== 3'd0 || adj_val !== 5'd0) begin n_fail++; $display("FAIL midrst_adj: got state %0d sel %0d val %0d, required 0 0 0", state, adj_sel, adj_val); end
        n_checks++; if (cnt_rst !== 1'b1 || paused !== 1'b1) begin n_fail++; $display("FAIL midrst_flags: got cnt_rst %b paused %b, required 1 1", cnt_rst, paused); end
        @(negedge clk); rst = 1'b0;
        repeat (SETTLE) @(negedge clk);
        btn[0] = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1; btn[0] = 1'b0;
        @(negedge clk); rst = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            @(negedge clk);
            if (state !== 2'd0 || paused !== 1'b1) bad++;
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL inflight_press: got %0d bad cycles, required 0", bad); end
    endtask

    task automatic test_random();
        int act, hold;
        logic exp_p;
        @(negedge clk); rst = 1'b1; sw = 1'b0; btn = 4'b0000;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_state = 0; m_sel = 0; m_val = 0; m_sw = 1'b0;
        repeat (SETTLE) @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            act  = $urandom_range(0, 4);
            hold = $urandom_range(1, 8);
            if (act < 4) begin
                press(act, hold);
                if (hold >= DB) m_event(act);
            end else if (hold >= DB) begin
                set_sw(~sw);
                m_switch(sw);
            end else begin
                @(negedge clk); sw = ~sw;
                repeat (hold) @(negedge clk);
                sw = ~sw;
                repeat (SETTLE) @(negedge clk);
            end
            exp_p = (m_state != 1);
            n_checks++; if (state !== 2'(m_state)) begin n_fail++; $display("FAIL rand_state step %0d: got %0d, required %0d", i, state, m_state); end
            n_checks++; if (paused !== exp_p) begin n_fail++; $display("FAIL rand_paused step %0d: got %b, required %b", i, paused, exp_p); end
            n_checks++; if (adj_sel !== 3'(m_sel)) begin n_fail++; $display("FAIL rand_sel step %0d: got %0d, required %0d", i, adj_sel, m_sel); end
            n_checks++; if (adj_val !== 5'(m_val)) begin n_fail++; $display("FAIL rand_val step %0d: got %0d, required %0d", i, adj_val, m_val); end
        end
    endtask

    initial begin
        test_reset();
        test_pause_toggle();
        test_glitch();
        test_clear();
        test_adjust();
        test_simultaneous();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Front-panel controller for the stopwatch `counter` block.
- Conditions raw push-buttons and the adjust switch.
- Runs a STOP/RUN/PAUSE/ADJ state machine.
- Drives the counter's `rst`, `paused`, `adj_sel` and `adj_val` inputs.
- Sits between board I/O and `counter`; the counter's digit outputs never feed back into it.

Parameters:
DB_CYCLES, 16, consecutive stable synchronized cycles required before a debounced level changes (min 2).
BLINK_DIV, 8, half-period in clk cycles of the adjust-digit blink (used only with the optional feature).

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
btn_pause  in  1  raw pause/run button, async
btn_reset  in  1  raw clear button, async
btn_sel  in  1  raw digit-select button, async
btn_inc  in  1  raw digit-increment button, async
sw_adj  in  1  raw adjust-mode switch (level), async
cnt_rst  out  1  clear pulse to counter
paused  out  1  freeze to counter
adj_sel  out  3  digit select to counter: 0 none, 1 min_l, 2 min_r, 3 sec_l, 4 sec_r
adj_val  out  5  value to load into selected digit
state  out  2  current FSM state (debug)

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. `rst` sampled at posedge clears every register, including synchronizers and debounce counters.
- Reset values: state=STOP(0), cnt_rst=1, paused=1, adj_sel=0, adj_val=0.
- Reset release: cnt_rst drops on the first edge with rst low.
- Input conditioning (each of the 5 inputs):
  - 2-flop synchronizer.
  - Debounce counter: counts cycles where synced ≠ debounced level; clears on any match; flips the level when the count reaches DB_CYCLES.
  - Button press pulse: debounced rising edge, registered, exactly 1 cycle wide.
  - Latency: raw rise held stable → pulse asserted exactly DB_CYCLES+3 posedges later.
  - Any glitch shorter than DB_CYCLES cycles produces no pulse.
  - sw_adj uses the debounced level only.
- State encoding: STOP=0, RUN=1, PAUSE=2, ADJ=3.
- STOP (paused=1):
  - pause_p → RUN.
  - sw_adj high → ADJ.
- RUN (paused=0):
  - pause_p → PAUSE.
  - sw_adj ignored.
- PAUSE (paused=1):
  - pause_p → RUN.
  - sw_adj high → ADJ.
- reset_p in STOP/RUN/PAUSE: cnt_rst=1 for exactly one cycle; next state STOP.
- Same-cycle priority outside ADJ: reset_p > sw_adj > pause_p.
- ADJ (paused=1):
  - Entry: adj_sel=1, adj_val=0.
  - sel_p: adj_sel advances 1→2→3→4→1; adj_val cleared to 0.
  - inc_p: adj_val+1, wrapping at the digit limit: min_l 0..5, min_r 0..9, sec_l 0..5, sec_r 0..9.
  - sel_p and inc_p in the same cycle: sel wins, inc dropped.
  - pause_p and reset_p ignored.
  - sw_adj low → PAUSE, with adj_sel=0 and adj_val=0 in that same transition.
- Outputs are registered; state changes take effect one cycle after the pulse.
- adj_val is always ≤ 9; bits [4] and any illegal combination are never driven.
- rst mid-ADJ or mid-debounce: immediate return to reset values; no pulse is emitted afterwards for a press already in flight.

Optional Feature:
STOPWATCH_BLINK_EN
- Defined:
  - Adds output port blink_mask[3:0], one bit per digit: bit3=min_l … bit0=sec_r.
  - In ADJ, the bit of the selected digit toggles every BLINK_DIV cycles, starting at 1 on ADJ entry.
  - Blink counter restarts on every sel_p.
  - Outside ADJ, and at reset: 4'b1111.
- Undefined:
  - Port and blink counter are absent.
  - All other behaviour is identical.

Decomposition:
- Package stopwatch_pkg:
  - State constants ST_STOP/ST_RUN/ST_PAUSE/ST_ADJ.
  - Selector codes SEL_NONE/SEL_MIN_L/SEL_MIN_R/SEL_SEC_L/SEL_SEC_R.
  - Digit limits LIM_TENS=5, LIM_ONES=9.
- Sub-module btn_debounce (params DB_CYCLES; ports clk, rst, raw → level, press):
  - Instantiated 5 times.
  - Press output unused for sw_adj.

Test Plan (DB_CYCLES=4, BLINK_DIV=4):
- Reset: rst high 3 cycles → cnt_rst=1, paused=1, state=0. One cycle after rst low → cnt_rst=0.
- Pause toggle: btn_pause high 10 cycles → paused falls exactly 8 cycles after raw rise (7 for pulse + 1 registered), state=1. Second press → paused=1, state=2.
- Debounce: 3-cycle glitch on btn_pause → no state change for 20 cycles.
- Clear: press btn_reset in RUN → cnt_rst high exactly 1 cycle, state=0, paused=1.
- Adjust: from PAUSE, sw_adj=1 → adj_sel=1, adj_val=0.
  - 7 inc presses → adj_val=1 (wraps at 5).
  - sel press → adj_sel=2, adj_val=0; 10 inc presses → adj_val=0.
  - sel ×3 → adj_sel=1.
  - sw_adj=0 → adj_sel=0, state=2.
- Simultaneous/ignored:
  - btn_sel and btn_inc released together in ADJ → adj_sel increments, adj_val=0.
  - btn_reset in ADJ → cnt_rst stays 0.
  - sw_adj=1 in RUN → state stays 1.
